// File: rtl/memory_access.sv
//------------------------------------------------------------------------------
// Module  : memory_access
// Brief   : Load/store unit issuing one data-memory bus transaction at a time.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package memory_access_pkg;
  typedef enum logic [2:0] {
    MATH   = 3'd0,
    LOAD   = 3'd1,
    STORE  = 3'd2,
    BRANCH = 3'd3,
    JUMP   = 3'd4
  } instr_type_t;

  typedef enum logic [2:0] {
    BYTE          = 3'd0,
    HALF          = 3'd1,
    WORD          = 3'd2,
    BYTE_UNSIGNED = 3'd3,
    HALF_UNSIGNED = 3'd4
  } mem_type_t;
endpackage

module memory_access
  import memory_access_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  instr_type_t in_instr_type,
  input  mem_type_t   in_mem_type,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  output logic        stall,
  output logic        out_valid,
  output logic [31:0] out_mem_rd,
  output logic        misaligned,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_addr;
  mem_type_t   r_mem_type;
  logic        r_we;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic        r_misaligned;
  logic [31:0] r_mem_rd;

  logic        w_accept;
  logic        w_is_byte;
  logic        w_is_half;
  logic        w_misaligned;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_shifted;
  logic [31:0] w_load_data;

  // Request decode: alignment, lane enables and replicated store data.
  always_comb begin
    w_is_byte    = (in_mem_type == BYTE) || (in_mem_type == BYTE_UNSIGNED);
    w_is_half    = (in_mem_type == HALF) || (in_mem_type == HALF_UNSIGNED);
    w_accept     = (r_state == S_IDLE) && in_valid &&
                   ((in_instr_type == LOAD) || (in_instr_type == STORE));
    w_misaligned = (w_is_half && in_addr[0]) ||
                   ((in_mem_type == WORD) && (in_addr[1:0] != 2'b00));
    w_be         = 4'b1111;
    w_wdata      = in_wdata;
    if (w_is_byte) begin
      w_be    = 4'b0001 << in_addr[1:0];
      w_wdata = {4{in_wdata[7:0]}};
    end else if (w_is_half) begin
      w_be    = 4'b0011 << in_addr[1:0];
      w_wdata = {2{in_wdata[15:0]}};
    end
  end

  // Load data is right-aligned and zero-filled; extension happens downstream.
  always_comb begin
    w_shifted = dmem_rdata >> {r_addr[1:0], 3'b000};
    case (r_mem_type)
      BYTE, BYTE_UNSIGNED: w_load_data = {24'd0, w_shifted[7:0]};
      HALF, HALF_UNSIGNED: w_load_data = {16'd0, w_shifted[15:0]};
      default:             w_load_data = w_shifted;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = w_misaligned ? S_DONE : S_REQ;
      S_REQ:   if (dmem_gnt) w_next = S_WAIT;
      S_WAIT:  if (dmem_rvalid) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_mem_type   <= BYTE;
      r_we         <= 1'b0;
      r_be         <= '0;
      r_wdata      <= '0;
      r_misaligned <= 1'b0;
      r_mem_rd     <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr       <= in_addr;
        r_mem_type   <= in_mem_type;
        r_we         <= (in_instr_type == STORE);
        r_be         <= w_be;
        r_wdata      <= w_wdata;
        r_misaligned <= w_misaligned;
        r_mem_rd     <= '0;
      end else if ((r_state == S_WAIT) && dmem_rvalid && !r_we) begin
        r_mem_rd <= w_load_data;
      end
    end
  end

  assign stall      = w_accept || (r_state == S_REQ) || (r_state == S_WAIT);
  assign out_valid  = (r_state == S_DONE);
  assign misaligned = (r_state == S_DONE) && r_misaligned;
  assign out_mem_rd = r_mem_rd;
  assign dmem_req   = (r_state == S_REQ);
  assign dmem_we    = r_we;
  assign dmem_be    = r_be;
  assign dmem_addr  = {r_addr[31:2], 2'b00};
  assign dmem_wdata = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_memory_access.sv
//------------------------------------------------------------------------------
// Module  : tb_memory_access
// Brief   : Scoreboard bench for memory_access with a randomizing bus responder.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_memory_access;
  import memory_access_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  instr_type_t in_instr_type;
  mem_type_t   in_mem_type;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic        stall;
  logic        out_valid;
  logic [31:0] out_mem_rd;
  logic        misaligned;
  logic        dmem_req;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  memory_access dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr_type(in_instr_type),
    .in_mem_type(in_mem_type), .in_addr(in_addr), .in_wdata(in_wdata),
    .stall(stall), .out_valid(out_valid), .out_mem_rd(out_mem_rd),
    .misaligned(misaligned), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_be(dmem_be), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct {
    logic        mis;
    logic [31:0] rd;
  } res_exp_t;

  bus_exp_t bus_q[$];
  res_exp_t res_q[$];
  int checks   = 0;
  int failures = 0;

  // Byte-addressed memories: one for the reference model, one behind the bus.
  logic [7:0] ref_mem [logic [31:0]];
  logic [7:0] bus_mem [logic [31:0]];

  int  g_dly = 0;
  int  r_dly = 0;
  bit  noise = 1'b0;
  int  resp_phase = 0;
  int  resp_cnt   = 0;
  logic [31:0] resp_addr;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endfunction

  function automatic logic [7:0] init_byte(logic [31:0] a);
    return 8'((a * 32'd37) + (a >> 5));
  endfunction

  function automatic logic [7:0] ref_rd(logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] bus_rd(logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : init_byte(a);
  endfunction

  function automatic int size_of(mem_type_t mt);
    if (mt == BYTE || mt == BYTE_UNSIGNED) return 1;
    if (mt == HALF || mt == HALF_UNSIGNED) return 2;
    return 4;
  endfunction

  // Reference model: derive bus and result expectations from the access itself.
  task automatic expect_access(input instr_type_t it, input mem_type_t mt,
                               input logic [31:0] a, input logic [31:0] wd,
                               input bit push_res, output bit mis);
    int          sz;
    logic [3:0]  be;
    logic [31:0] wl;
    logic [31:0] rd;
    sz  = size_of(mt);
    mis = (a % sz) != 0;
    rd  = '0;
    if (!mis) begin
      be = '0;
      wl = '0;
      for (int i = 0; i < sz; i++) be[int'(a[1:0]) + i] = 1'b1;
      for (int k = 0; k < 4; k++) wl[8*k +: 8] = wd[8*(k % sz) +: 8];
      bus_q.push_back('{addr: {a[31:2], 2'b00}, be: be, we: (it == STORE), wdata: wl});
      for (int i = 0; i < sz; i++) begin
        if (it == STORE) ref_mem[a + 32'(i)] = wd[8*i +: 8];
        else             rd[8*i +: 8] = ref_rd(a + 32'(i));
      end
    end
    if (push_res) res_q.push_back('{mis: mis, rd: rd});
  endtask

  // Called at posedge+1; returns at posedge+1 after the pipeline moves on.
  task automatic issue(input bit v, input instr_type_t it, input mem_type_t mt,
                       input logic [31:0] a, input logic [31:0] wd);
    bit mis;
    bit is_mem;
    int n_stall;
    int exp_stall;
    is_mem = v && (it == LOAD || it == STORE);
    mis    = 1'b0;
    if (is_mem) expect_access(it, mt, a, wd, 1'b1, mis);
    exp_stall = !is_mem ? 0 : (mis ? 1 : 3 + g_dly + r_dly);
    in_valid      = v;
    in_instr_type = it;
    in_mem_type   = mt;
    in_addr       = a;
    in_wdata      = wd;
    n_stall = 0;
    forever begin
      @(negedge clk);
      if (!stall) break;
      n_stall++;
      if (n_stall > 200) break;
    end
    chk("stall_cycles", 32'(n_stall), 32'(exp_stall));
    chk("valid_when_stall_drops", {31'd0, out_valid}, {31'd0, is_mem});
    if (!is_mem) chk("no_req_idle", {31'd0, dmem_req}, 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_addr  = $urandom;
    in_wdata = $urandom;
  endtask

  // Bus responder with programmable grant/response delays and optional noise.
  initial begin
    dmem_gnt = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata = '0;
    forever begin
      @(negedge clk);
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b0;
      dmem_rdata  = $urandom;
      if (!rst_n) continue;
      if (resp_phase == 0) begin
        if (dmem_req && resp_cnt >= g_dly) begin
          dmem_gnt  = 1'b1;
          resp_addr = dmem_addr;
          if (dmem_we)
            for (int k = 0; k < 4; k++)
              if (dmem_be[k]) bus_mem[dmem_addr + 32'(k)] = dmem_wdata[8*k +: 8];
          resp_phase = 1;
          resp_cnt   = 0;
          if (noise) dmem_rvalid = 1'($urandom_range(0, 1));
        end else begin
          if (dmem_req) resp_cnt++;
          if (noise) dmem_rvalid = 1'($urandom_range(0, 1));
        end
      end else begin
        if (resp_cnt >= r_dly) begin
          dmem_rvalid = 1'b1;
          for (int k = 0; k < 4; k++) dmem_rdata[8*k +: 8] = bus_rd(resp_addr + 32'(k));
          resp_phase = 0;
          resp_cnt   = 0;
        end else begin
          resp_cnt++;
          if (noise) dmem_gnt = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  // Monitor: bus requests and completions are popped from the scoreboard.
  initial begin
    bus_exp_t be_exp;
    res_exp_t re_exp;
    bit       prev_req;
    logic [31:0] h_addr, h_wdata;
    logic [3:0]  h_be;
    logic        h_we;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_req = 1'b0;
        continue;
      end
      if (dmem_req && !prev_req) begin
        if (bus_q.size() == 0) begin
          chk("unexpected_req", 32'd1, 32'd0);
        end else begin
          be_exp = bus_q.pop_front();
          chk("dmem_addr", dmem_addr, be_exp.addr);
          chk("dmem_be", {28'd0, dmem_be}, {28'd0, be_exp.be});
          chk("dmem_we", {31'd0, dmem_we}, {31'd0, be_exp.we});
          if (be_exp.we) chk("dmem_wdata", dmem_wdata, be_exp.wdata);
        end
        h_addr = dmem_addr; h_be = dmem_be; h_we = dmem_we; h_wdata = dmem_wdata;
      end else if (dmem_req) begin
        chk("req_hold_addr", dmem_addr, h_addr);
        chk("req_hold_ctl", {27'd0, h_we, dmem_be}, {27'd0, dmem_we, h_be});
        chk("req_hold_wdata", dmem_wdata, h_wdata);
      end
      prev_req = dmem_req;
      if (out_valid) begin
        if (res_q.size() == 0) begin
          chk("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          re_exp = res_q.pop_front();
          chk("misaligned", {31'd0, misaligned}, {31'd0, re_exp.mis});
          chk("out_mem_rd", out_mem_rd, re_exp.rd);
        end
      end else if (misaligned) begin
        chk("misaligned_without_valid", 32'd1, 32'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          mis;
    int          n;
    instr_type_t it;
    in_valid = 1'b0; in_instr_type = MATH; in_mem_type = BYTE;
    in_addr = '0; in_wdata = '0;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_misaligned", {31'd0, misaligned}, 32'd0);
    chk("rst_out_mem_rd", out_mem_rd, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Byte load from the top lane, minimum latency.
    for (int k = 0; k < 4; k++) begin
      ref_mem[32'h100 + 32'(k)] = 8'(32'hAABBCCDD >> (8*k));
      bus_mem[32'h100 + 32'(k)] = 8'(32'hAABBCCDD >> (8*k));
    end
    g_dly = 0; r_dly = 0;
    issue(1'b1, LOAD, BYTE, 32'h103, 32'h5555_5555);
    issue(1'b1, STORE, HALF, 32'h202, 32'h1234_ABCD);
    issue(1'b1, LOAD, HALF_UNSIGNED, 32'h202, 32'h0);
    issue(1'b1, LOAD, WORD, 32'h6, 32'h0);
    issue(1'b1, LOAD, HALF, 32'h101, 32'h0);
    g_dly = 5; r_dly = 3;
    issue(1'b1, LOAD, WORD, 32'h300, 32'h0);
    g_dly = 0; r_dly = 0;
    issue(1'b1, MATH, WORD, 32'h400, 32'h0);

    // Reset while waiting for the response; the late response must be ignored.
    r_dly = 8;
    expect_access(LOAD, WORD, 32'h40, 32'h0, 1'b0, mis);
    in_valid = 1'b1; in_instr_type = LOAD; in_mem_type = WORD; in_addr = 32'h40;
    n = 0;
    while (resp_phase != 1 && n < 20) begin
      @(posedge clk);
      n++;
    end
    chk("reset_test_granted", 32'(resp_phase), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_wait_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_wait_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_wait_stall_follows_in", {31'd0, stall}, 32'd1);
    in_valid = 1'b0;
    #1;
    chk("rst_wait_stall_idle", {31'd0, stall}, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    n = 0;
    while (resp_phase != 0 && n < 30) begin
      @(posedge clk);
      n++;
    end
    chk("stale_rvalid_delivered", 32'(resp_phase), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    r_dly = 0;
    issue(1'b1, LOAD, WORD, 32'h40, 32'h0);

    // Randomized traffic with bus noise and random delays.
    noise = 1'b1;
    for (int t = 0; t < 300; t++) begin
      n = $urandom_range(0, 9);
      it = (n < 4) ? LOAD : (n < 8) ? STORE : instr_type_t'($urandom_range(3, 4) - (n == 9 ? 3 : 0));
      g_dly = $urandom_range(0, 3);
      r_dly = $urandom_range(0, 3);
      issue(1'($urandom_range(0, 7) != 0), it, mem_type_t'($urandom_range(0, 4)),
            32'h1000 + 32'($urandom_range(0, 31)), $urandom);
    end

    repeat (5) @(posedge clk);
    chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
    chk("res_q_drained", 32'(res_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
